// File: rtl/sif_pkg.sv
// Shared types and constants for the SIF bridge.
package sif_pkg;

  localparam int unsigned SIF_DW     = 16;
  localparam int unsigned SIF_AW     = 16;
  localparam int unsigned DROP_CNT_W = 8;

  // Forwarded write payload at the default bus widths
  typedef struct packed {
    logic [SIF_AW-1:0] addr;
    logic [SIF_DW-1:0] data;
  } sif_entry_t;

  // Saturating increment for the drop counter
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : DROP_CNT_W'(v + 1'b1);
  endfunction

endpackage

// File: rtl/sif_fifo.sv
// Forward FIFO: registered array, head read straight from storage.
module sif_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is masked to zero when empty so stale storage never shows on the bus
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since empty masks the head
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sif_bridge.sv
// SIF host target with shadow registers and buffered multi-channel write forwarding.
module sif_bridge
  import sif_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREG  = 16,
  parameter int unsigned NCH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         xa_addr,
  input  logic [DW-1:0]         xa_data_wr,
  input  logic                  xa_wr_s,
  input  logic                  xa_rd_s,
  output logic [DW-1:0]         xa_data_rd,
  output logic                  xa_rd_valid,
  output logic                  xa_busy,
  output logic [AW-1:0]         wa_addr,
  output logic [DW-1:0]         wa_data_wr,
  output logic [NCH-1:0]        wa_wr_s,
  input  logic [NCH-1:0]        wa_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned CHB  = (NCH > 1) ? $clog2(NCH) : 0;
  localparam int unsigned CHW  = (CHB > 0) ? CHB : 1;
  localparam int unsigned IDXW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned EW   = AW + DW;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;

  logic [EW-1:0]   fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            wr_accept;
  logic            wr_drop;
  logic            fwd_pop;
  logic [CHW-1:0]  head_ch;
  logic [IDXW-1:0] reg_idx;
  logic [DW-1:0]   shadow [NREG];

  assign reg_idx   = xa_addr[IDXW-1:0];
  assign xa_busy   = (fifo_count == CW'(DEPTH));
  assign wr_accept = xa_wr_s && !fifo_full;
  assign wr_drop   = xa_wr_s && fifo_full;

  sif_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_accept),
    .pop   (fwd_pop),
    .din   ({xa_addr, xa_data_wr}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign wa_addr    = fifo_head[EW-1 -: AW];
  assign wa_data_wr = fifo_head[DW-1:0];

  // Channel select comes from the top address bits of the head entry
  generate
    if (CHB > 0) begin : g_ch_sel
      assign head_ch = wa_addr[AW-1 -: CHB];
    end else begin : g_ch_single
      assign head_ch = '0;
    end
  endgenerate

  // One-hot channel valid from FIFO state; pop on the selected channel's ready
  always_comb begin
    wa_wr_s = '0;
    if (!fifo_empty) begin
      wa_wr_s = NCH'(1) << head_ch;
    end
    fwd_pop = |(wa_wr_s & wa_ready);
  end

  // Shadow register file, updated only by accepted writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_accept) begin
      shadow[reg_idx] <= xa_data_wr;
    end
  end

  // One-cycle read return; samples the pre-write value on a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      xa_rd_valid <= 1'b0;
      xa_data_rd  <= '0;
    end else begin
      xa_rd_valid <= xa_rd_s;
      if (xa_rd_s) begin
        xa_data_rd <= shadow[reg_idx];
      end
    end
  end

  // Saturating count of writes refused while full
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (wr_drop) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_sif_bridge.sv
// Bench for sif_bridge: directed table, corner sequences, randomized run against a queue model.
module tb_sif_bridge;
  import sif_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] xa_addr;
  logic [15:0] xa_data_wr;
  logic        xa_wr_s;
  logic        xa_rd_s;
  logic [15:0] xa_data_rd;
  logic        xa_rd_valid;
  logic        xa_busy;
  logic [15:0] wa_addr;
  logic [15:0] wa_data_wr;
  logic [1:0]  wa_wr_s;
  logic [1:0]  wa_ready;
  logic [7:0]  drop_cnt;

  sif_bridge #(
    .DW(16), .AW(16), .DEPTH(DEPTH), .NREG(16), .NCH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .xa_addr     (xa_addr),
    .xa_data_wr  (xa_data_wr),
    .xa_wr_s     (xa_wr_s),
    .xa_rd_s     (xa_rd_s),
    .xa_data_rd  (xa_data_rd),
    .xa_rd_valid (xa_rd_valid),
    .xa_busy     (xa_busy),
    .wa_addr     (wa_addr),
    .wa_data_wr  (wa_data_wr),
    .wa_wr_s     (wa_wr_s),
    .wa_ready    (wa_ready),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: ordered queue of pending writes, register array, drop tally
  sif_entry_t  q[$];
  logic [15:0] shadow_m [16];
  int          drops_m;
  int          xfer_total;
  int          xfer_ch0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  ready;
    logic        exp_rv;
    logic [15:0] exp_rd;
    logic [1:0]  exp_s;
    logic [15:0] exp_wa;
    logic [15:0] exp_wd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; checks bus state before the edge and read/drop results after
  task automatic cycle(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [15:0] data, input logic [1:0] ready);
    sif_entry_t  hd;
    logic [1:0]  exp_s;
    logic [15:0] exp_rd;
    bit          acc;
    bit          pop;
    xa_wr_s    = wr;
    xa_rd_s    = rd;
    xa_addr    = addr;
    xa_data_wr = data;
    wa_ready   = ready;
    #1;
    if (q.size() != 0) begin
      hd    = q[0];
      exp_s = hd.addr[15] ? 2'b10 : 2'b01;
    end else begin
      hd    = '0;
      exp_s = 2'b00;
    end
    chk("wa_wr_s", 32'(wa_wr_s), 32'(exp_s));
    chk("wa_addr", 32'(wa_addr), 32'(hd.addr));
    chk("wa_data_wr", 32'(wa_data_wr), 32'(hd.data));
    chk("xa_busy", 32'(xa_busy), 32'(q.size() == DEPTH));
    if ((wa_wr_s & ready) != 2'b00) begin
      xfer_total++;
      if (wa_wr_s[0]) xfer_ch0++;
    end
    pop    = (q.size() != 0) && ready[hd.addr[15] ? 1 : 0];
    acc    = wr && (q.size() < DEPTH);
    exp_rd = shadow_m[addr[3:0]];
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back('{addr: addr, data: data});
      shadow_m[addr[3:0]] = data;
    end else if (wr && drops_m < 255) begin
      drops_m++;
    end
    chk("xa_rd_valid", 32'(xa_rd_valid), 32'(rd));
    if (rd) chk("xa_data_rd", 32'(xa_data_rd), 32'(exp_rd));
    chk("drop_cnt", 32'(drop_cnt), 32'(drops_m));
  endtask

  // Reset with random strobes asserted, then confirm every output is cleared
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xa_wr_s    = 1'($urandom);
      xa_rd_s    = 1'($urandom);
      xa_addr    = 16'($urandom);
      xa_data_wr = 16'($urandom);
      wa_ready   = 2'($urandom);
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    xa_wr_s  = 1'b0;
    xa_rd_s  = 1'b0;
    wa_ready = 2'b00;
    q.delete();
    for (int i = 0; i < 16; i++) shadow_m[i] = 16'h0000;
    drops_m = 0;
    chk("rst xa_rd_valid", 32'(xa_rd_valid), 32'd0);
    chk("rst xa_data_rd", 32'(xa_data_rd), 32'd0);
    chk("rst wa_wr_s", 32'(wa_wr_s), 32'd0);
    chk("rst wa_addr", 32'(wa_addr), 32'd0);
    chk("rst wa_data_wr", 32'(wa_data_wr), 32'd0);
    chk("rst xa_busy", 32'(xa_busy), 32'd0);
    chk("rst drop_cnt", 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    int          base_total;
    int          base_ch0;
    logic [15:0] stall_addr;
    logic [15:0] stall_data;

    rst        = 1'b1;
    xa_wr_s    = 1'b0;
    xa_rd_s    = 1'b0;
    xa_addr    = '0;
    xa_data_wr = '0;
    wa_ready   = '0;
    xfer_total = 0;
    xfer_ch0   = 0;
    drops_m    = 0;

    // Reset with strobes active, then every shadow register reads zero
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 16'(i), 16'h0, 2'b11);
    end

    // Directed table: forwarding, read return, read-before-write
    //          wr    rd    addr      data      ready  rv    rd_data   wa_s   wa_addr   wa_data
    tbl[0] = '{1'b1, 1'b0, 16'h8003, 16'hBEEF, 2'b11, 1'b0, 16'h0000, 2'b10, 16'h8003, 16'hBEEF};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 16'h0003, 16'h0000, 2'b11, 1'b1, 16'hBEEF, 2'b00, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 16'h0005, 16'h1111, 2'b11, 1'b0, 16'h0000, 2'b01, 16'h0005, 16'h1111};
    tbl[4] = '{1'b1, 1'b1, 16'h0005, 16'h2222, 2'b11, 1'b1, 16'h1111, 2'b01, 16'h0005, 16'h2222};
    tbl[5] = '{1'b0, 1'b1, 16'h0005, 16'h0000, 2'b11, 1'b1, 16'h2222, 2'b00, 16'h0000, 16'h0000};
    tbl[6] = '{1'b0, 1'b1, 16'h8005, 16'h0000, 2'b11, 1'b1, 16'h2222, 2'b00, 16'h0000, 16'h0000};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].ready);
      chk($sformatf("tbl%0d rd_valid", i), 32'(xa_rd_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) chk($sformatf("tbl%0d rd_data", i), 32'(xa_data_rd), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d wa_wr_s", i), 32'(wa_wr_s), 32'(tbl[i].exp_s));
      chk($sformatf("tbl%0d wa_addr", i), 32'(wa_addr), 32'(tbl[i].exp_wa));
      chk($sformatf("tbl%0d wa_data", i), 32'(wa_data_wr), 32'(tbl[i].exp_wd));
    end

    // Backpressure: four writes fill, fifth dropped, then in-order drain
    do_reset();
    cycle(1'b1, 1'b0, 16'h0001, 16'hA001, 2'b00);
    cycle(1'b1, 1'b0, 16'h8002, 16'hA002, 2'b00);
    cycle(1'b1, 1'b0, 16'h0003, 16'hA003, 2'b00);
    chk("busy before full", 32'(xa_busy), 32'd0);
    cycle(1'b1, 1'b0, 16'h8004, 16'hA004, 2'b00);
    chk("busy when full", 32'(xa_busy), 32'd1);
    cycle(1'b1, 1'b0, 16'h0005, 16'hA005, 2'b00);
    chk("drop one", 32'(drop_cnt), 32'd1);
    stall_addr = wa_addr;
    stall_data = wa_data_wr;
    chk("stalled head addr", 32'(stall_addr), 32'h0001);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    chk("stable addr", 32'(wa_addr), 32'(stall_addr));
    chk("stable data", 32'(wa_data_wr), 32'(stall_data));
    base_total = xfer_total;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 2'b11);
    chk("drain count", 32'(xfer_total - base_total), 32'd4);
    cycle(1'b0, 1'b1, 16'h0005, 16'h0, 2'b11);
    chk("dropped not shadowed", 32'(xa_data_rd), 32'h0000);

    // Head-of-line: stalled ch1 head blocks a ready ch0 entry behind it
    do_reset();
    cycle(1'b1, 1'b0, 16'h8001, 16'hC001, 2'b01);
    cycle(1'b1, 1'b0, 16'h0002, 16'hC002, 2'b01);
    base_ch0 = xfer_ch0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 2'b01);
    chk("hol no ch0", 32'(xfer_ch0 - base_ch0), 32'd0);
    chk("hol head ch1", 32'(wa_wr_s), 32'h2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 2'b11);
    chk("hol ch0 after", 32'(xfer_ch0 - base_ch0), 32'd1);

    // Saturation: fill, then 300 writes while full
    do_reset();
    for (int i = 0; i < 304; i++) begin
      cycle(1'b1, 1'b0, 16'($urandom), 16'($urandom), 2'b00);
    end
    chk("drop saturate", 32'(drop_cnt), 32'd255);

    // Randomized traffic against the model, with occasional resets
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [1:0] rdy;
      if ($urandom_range(0, 199) == 0) do_reset();
      rdy[0] = ($urandom_range(0, 3) != 0);
      rdy[1] = ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
            16'($urandom), 16'($urandom), rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sif_bridge.md
# sif_bridge

Parametrised successor to the single-channel SIF target. It accepts host (xa) write and read strobes and keeps a shadow register file that host reads return from. Accepted writes are forwarded through a buffered FIFO to one of NCH downstream (wa) write channels, with per-channel ready backpressure. It sits between the SIF host driver and the downstream write sinks, and adds buffering, flow control, channel steering and drop accounting.

## Interface
- DW, 16, data width (xa and wa)
- AW, 16, address width (xa and wa)
- DEPTH, 4, forward FIFO entries; power of 2, ≥2
- NREG, 16, shadow registers; power of 2, ≤2^(AW-CHB)
- NCH, 2, downstream channels; power of 2, ≥1; CHB = $clog2(NCH), 0 when NCH=1

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- xa_addr  in  AW  host address; top CHB bits select channel, low $clog2(NREG) bits index the shadow register
- xa_data_wr  in  DW  host write data
- xa_wr_s  in  1  host write strobe, one write per cycle
- xa_rd_s  in  1  host read strobe
- xa_data_rd  out  DW  read data, valid when xa_rd_valid=1
- xa_rd_valid  out  1  read-return pulse
- xa_busy  out  1  FIFO full; writes presented now are dropped
- wa_addr  out  AW  forwarded address (FIFO head)
- wa_data_wr  out  DW  forwarded data (FIFO head)
- wa_wr_s  out  NCH  per-channel valid, one-hot or zero
- wa_ready  in  NCH  per-channel sink ready
- drop_cnt  out  8  saturating count of dropped writes

## Operation
- Write accept: xa_wr_s && !xa_busy. On accept:
  - push {xa_addr, xa_data_wr} into the FIFO;
  - write shadow[xa_addr[idx]] = xa_data_wr.
- Write drop: xa_wr_s && xa_busy.
  - No push and no shadow update.
  - drop_cnt increments and saturates at 255.
- Read:
  - xa_rd_s is always accepted, including when busy.
  - The next cycle: xa_rd_valid=1 and xa_data_rd = shadow[idx] sampled on the xa_rd_s cycle.
  - Same-cycle xa_wr_s + xa_rd_s to the same index returns the old value (read-before-write). The write still applies.
- Forward:
  - When the FIFO is non-empty, wa_wr_s[ch] = 1 with ch = head wa_addr[AW-1 -: CHB]. Channel 0 when NCH=1.
  - Pop when wa_wr_s[ch] && wa_ready[ch].
  - wa_addr and wa_data_wr stay stable while wa_wr_s is high and not yet accepted.
- Ordering: strict FIFO across all channels. A stalled head blocks writes queued for other channels (head-of-line blocking by design).
- xa_busy = (count == DEPTH), derived from registered count.
  - When full, a simultaneous pop does not let a same-cycle write in; that write is dropped.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.

## Timing
- Reset (rst=1 at an edge) clears:
  - FIFO pointers and count;
  - all shadow registers;
  - drop_cnt;
  - xa_rd_valid, xa_data_rd, wa_wr_s, wa_addr, wa_data_wr (all 0), and xa_busy=0.
- Reset mid-operation discards FIFO contents and any pending read return. Strobes sampled during reset are ignored.
- Write latency: accept at edge T with FIFO empty → wa_wr_s high after T, sampled by the sink at T+1.
- Read latency: 1 cycle, with no bubble for back-to-back reads.
- Throughput: 1 write/cycle in, 1 transfer/cycle out.
- All outputs are registered or driven directly from registered FIFO state; there are no combinational input→output paths except wa_wr_s, which is a pure function of FIFO state and head address.

## Structure
- Package sif_pkg:
  - typedef sif_entry_t {addr, data}, parametrised via localparams of the default widths;
  - DROP_CNT_W = 8.
- Sub-module sif_fifo (DEPTH, entry width):
  - push, pop, head, full, empty, count;
  - no prefetch; the head is read from the registered array.
- Top level holds the shadow register file, read pipeline, channel decode and drop counter.

## Test plan
- Reset: drive strobes during rst=1 → all outputs 0 afterwards, shadow reads return 0x0000, drop_cnt=0.
- Write/forward: write addr 0x8003 data 0xBEEF with wa_ready=2'b11 → one cycle later wa_wr_s=2'b10, wa_addr=0x8003, wa_data_wr=0xBEEF, popped the same cycle. A later read of 0x0003 returns 0xBEEF.
- Backpressure/full: wa_ready=0, then 5 consecutive writes →
  - xa_busy=1 after the 4th;
  - 5th dropped, drop_cnt=1;
  - on release, exactly 4 transfers in order with stable data while stalled.
- Head-of-line: queue ch1 then ch0 writes, with wa_ready[1]=0 and wa_ready[0]=1 → no ch0 transfer until ch1 is accepted.
- Read-before-write: same cycle xa_wr_s=1 and xa_rd_s=1 to index 5 (old 0x1111, new 0x2222) → xa_data_rd=0x1111; the next read returns 0x2222.
- Saturation: 300 writes while full → drop_cnt holds at 255.
